// File: rtl/hubris_pkg.sv
// Shared Hubris core constants and fetch FSM state encodings.
package hubris_pkg;

   localparam int unsigned     XLEN     = 32;
   localparam int unsigned     INST_W   = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO holding fetched {pc, inst} pairs; flush wins over push.
module fetch_fifo #(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned W     = 64,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_c, pop_ok_c;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pop_ok_c  = pop && !empty;
      push_ok_c = push && (!full || pop_ok_c);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Hubris instruction fetch: owns the PC, issues 1-cycle imem reads and buffers
// {pc, inst} pairs for decode; redirects bump an epoch so stale responses are dropped.
module fetch_stage #(
   parameter int unsigned     XLEN       = hubris_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = hubris_pkg::RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [XLEN-1:0]               imem_addr,
   output logic                          imem_read_en,
   input  logic [hubris_pkg::INST_W-1:0] imem_read_data,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [XLEN-1:0]               out_pc,
   output logic [hubris_pkg::INST_W-1:0] out_inst
);

   import hubris_pkg::*;

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam int unsigned PKT_W = XLEN + INST_W;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            epoch_q, epoch_d;
   logic            req_epoch_q, req_epoch_d;

   logic             issue_c, push_c, pop_c;
   logic [OCC_W-1:0] occ_c;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic [PKT_W-1:0] fifo_rdata;

   // Credit check: buffered + in-flight words after this cycle's pop must leave room.
   assign pop_c   = !fifo_empty && out_ready;
   assign occ_c   = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop_c);
   assign issue_c = (state_q == S_RUN) && !redirect_valid && (occ_c < OCC_W'(FIFO_DEPTH));
   assign push_c  = inflight_q && (req_epoch_q == epoch_q) && !redirect_valid
                    && (!fifo_full || pop_c);

   assign imem_read_en       = issue_c;
   assign imem_addr          = pc_q;
   assign out_valid          = !fifo_empty;
   assign {out_pc, out_inst} = fifo_rdata;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      epoch_d     = epoch_q;
      req_pc_d    = req_pc_q;
      req_epoch_d = req_epoch_q;
      inflight_d  = issue_c;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
      if (issue_c) begin
         pc_d        = pc_q + XLEN'(4);
         req_pc_d    = pc_q;
         req_epoch_d = epoch_q;
      end
      // Redirect overrides everything, including the BOOT and FLUSH bubbles.
      if (redirect_valid) begin
         pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
         epoch_d = ~epoch_q;
         state_d = S_FLUSH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         inflight_q  <= 1'b0;
         epoch_q     <= 1'b0;
         req_epoch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         inflight_q  <= inflight_d;
         epoch_q     <= epoch_d;
         req_epoch_q <= req_epoch_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (pop_c),
      .flush (redirect_valid),
      .wdata ({req_pc_q, imem_read_data}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 1-cycle memory model plus an in-order stream model
// (next expected pc advances by 4 per accepted word, jumps on redirect).
module tb_fetch_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   logic            clk            = 1'b0;
   logic            rst_n          = 1'b0;
   logic [XLEN-1:0] imem_addr;
   logic            imem_read_en;
   logic [31:0]     imem_read_data = '0;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc    = '0;
   logic            out_valid;
   logic            out_ready      = 1'b0;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_inst;

   int n_checks = 0;
   int n_errors = 0;
   int n_accept = 0;

   logic [XLEN-1:0] exp_pc    = '0;
   logic            hold_v    = 1'b0;
   logic [XLEN-1:0] hold_pc   = '0;
   logic [31:0]     hold_inst = '0;

   fetch_stage #(
      .XLEN       (XLEN),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_read_en   (imem_read_en),
      .imem_read_data (imem_read_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   always #5 clk = ~clk;

   // Memory contents: word i holds i + 0x100.
   function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
      return (a >> 2) + 32'h100;
   endfunction

   always @(posedge clk) begin
      if (imem_read_en) imem_read_data <= inst_of(imem_addr);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   // Sample at the falling edge and run the stream model.
   task automatic at_neg();
      @(negedge clk);
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== hold_pc || out_inst !== hold_inst) begin
               n_errors++;
               $display("FAIL stall_hold: valid=%b pc=%h inst=%h, need valid=1 pc=%h inst=%h",
                        out_valid, out_pc, out_inst, hold_pc, hold_inst);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
               n_errors++;
               $display("FAIL stream_order: pc=%h inst=%h, need pc=%h inst=%h",
                        out_pc, out_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            n_accept++;
         end
         hold_v    = (out_valid === 1'b1) && !out_ready && !redirect_valid;
         hold_pc   = out_pc;
         hold_inst = out_inst;
         if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      at_neg();
      adv();
   endtask

   task automatic wait_valid(output logic ok, output logic [XLEN-1:0] pc, output logic [31:0] inst);
      ok   = 1'b0;
      pc   = '0;
      inst = '0;
      for (int i = 0; i < 10 && !ok; i++) begin
         at_neg();
         if (out_valid === 1'b1) begin
            ok   = 1'b1;
            pc   = out_pc;
            inst = out_inst;
         end
         adv();
      end
   endtask

   // Release reset and check the BOOT / issue / push timeline edge by edge.
   task automatic release_reset();
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      hold_v = 1'b0;
      at_neg();
      n_checks++;
      if (imem_read_en !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL boot_idle: read_en=%b valid=%b, need 0 0", imem_read_en, out_valid);
      end
      adv();
      at_neg();
      n_checks++;
      if (imem_read_en !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL first_req: read_en=%b addr=%h valid=%b, need 1 00000000 0",
                  imem_read_en, imem_addr, out_valid);
      end
      adv();
      at_neg();
      n_checks++;
      if (imem_read_en !== 1'b1 || imem_addr !== 32'h4 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL second_req: read_en=%b addr=%h valid=%b, need 1 00000004 0",
                  imem_read_en, imem_addr, out_valid);
      end
      adv();
      at_neg();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h100) begin
         n_errors++;
         $display("FAIL first_out: valid=%b pc=%h inst=%h, need 1 00000000 00000100",
                  out_valid, out_pc, out_inst);
      end
      adv();
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      repeat (6) cycle();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (imem_read_en !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 ||
          out_pc !== 32'h0 || out_inst !== 32'h0) begin
         n_errors++;
         $display("FAIL async_reset: read_en=%b addr=%h valid=%b pc=%h inst=%h, need all 0",
                  imem_read_en, imem_addr, out_valid, out_pc, out_inst);
      end
      repeat (2) cycle();
      n_checks++;
      if (imem_read_en !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_hold: read_en=%b valid=%b pc=%h, need 0 0 0",
                  imem_read_en, out_valid, out_pc);
      end
      release_reset();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         at_neg();
         n_checks++;
         if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_gap: cycle %0d valid=%b, need 1", i, out_valid);
         end
         adv();
      end
   endtask

   task automatic test_back_pressure();
      logic [XLEN-1:0] stall_pc;
      out_ready = 1'b1;
      repeat (3) cycle();
      out_ready = 1'b0;
      at_neg();
      stall_pc = out_pc;
      adv();
      for (int i = 0; i < 4; i++) begin
         at_neg();
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== stall_pc || imem_read_en !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stall: valid=%b pc=%h read_en=%b, need 1 %h 0",
                     out_valid, out_pc, imem_read_en, stall_pc);
         end
         adv();
      end
      out_ready = 1'b1;
      at_neg();
      n_checks++;
      if (out_pc !== stall_pc || imem_read_en !== 1'b1 || imem_addr !== stall_pc + 4 * DEPTH) begin
         n_errors++;
         $display("FAIL resume_fetch: pc=%h read_en=%b addr=%h, need %h 1 %h",
                  out_pc, imem_read_en, imem_addr, stall_pc, stall_pc + 4 * DEPTH);
      end
      adv();
      repeat (8) cycle();
   endtask

   task automatic test_redirect();
      logic            ok;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      out_ready = 1'b1;
      repeat (4) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      at_neg();
      n_checks++;
      if (imem_read_en !== 1'b0) begin
         n_errors++;
         $display("FAIL redirect_no_issue: read_en=%b, need 0", imem_read_en);
      end
      adv();
      redirect_valid = 1'b0;
      at_neg();
      n_checks++;
      if (out_valid !== 1'b0 || imem_read_en !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_bubble: valid=%b read_en=%b, need 0 0", out_valid, imem_read_en);
      end
      adv();
      at_neg();
      n_checks++;
      if (imem_read_en !== 1'b1 || imem_addr !== 32'h40) begin
         n_errors++;
         $display("FAIL refetch_addr: read_en=%b addr=%h, need 1 00000040", imem_read_en, imem_addr);
      end
      adv();
      wait_valid(ok, pc, inst);
      n_checks++;
      if (!ok || pc !== 32'h40 || inst !== inst_of(32'h40)) begin
         n_errors++;
         $display("FAIL post_redirect: seen=%b pc=%h inst=%h, need 1 00000040 %h",
                  ok, pc, inst, inst_of(32'h40));
      end
      repeat (4) cycle();
   endtask

   task automatic test_corner();
      logic            ok;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      int              acc0;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      cycle();
      redirect_valid = 1'b0;
      wait_valid(ok, pc, inst);
      n_checks++;
      if (!ok || pc !== 32'h40) begin
         n_errors++;
         $display("FAIL unaligned_redirect: seen=%b pc=%h, need 1 00000040", ok, pc);
      end
      repeat (3) cycle();

      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      wait_valid(ok, pc, inst);
      n_checks++;
      if (!ok || pc !== 32'hFFFF_FFFC) begin
         n_errors++;
         $display("FAIL top_of_mem: seen=%b pc=%h, need 1 fffffffc", ok, pc);
      end
      at_neg();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h100) begin
         n_errors++;
         $display("FAIL pc_wrap: valid=%b pc=%h inst=%h, need 1 00000000 00000100",
                  out_valid, out_pc, out_inst);
      end
      adv();
      repeat (3) cycle();

      out_ready = 1'b0;
      repeat (4) cycle();
      acc0           = n_accept;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      at_neg();
      n_checks++;
      if (n_accept != acc0 + 1) begin
         n_errors++;
         $display("FAIL redirect_pop_once: accepted=%0d, need 1", n_accept - acc0);
      end
      adv();
      redirect_valid = 1'b0;
      at_neg();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL redirect_flushed: valid=%b pc=%h, need 0", out_valid, out_pc);
      end
      adv();
      wait_valid(ok, pc, inst);
      n_checks++;
      if (!ok || pc !== 32'h80) begin
         n_errors++;
         $display("FAIL redirect_pop_target: seen=%b pc=%h, need 1 00000080", ok, pc);
      end
      repeat (3) cycle();
   endtask

   task automatic test_random();
      int acc0;
      acc0 = n_accept;
      for (int i = 0; i < 1500; i++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom();
         cycle();
      end
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      repeat (6) cycle();
      n_checks++;
      if (n_accept - acc0 < 300) begin
         n_errors++;
         $display("FAIL random_progress: accepted=%0d, need at least 300", n_accept - acc0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      repeat (3) adv();
      release_reset();
      test_streaming();
      test_reset();
      test_back_pressure();
      test_redirect();
      test_corner();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
